cache_controller: RTL and testbench

- Direct-mapped, write-through, one-word-per-line cache controller.
- Sits between the processor's load/store port and mainmeory.
- It is the initiator of every main-memory access: it drives the address, write data, write_signal, read_signal and match, and consumes dataoutput.
- Serves read hits locally; stalls the processor via cpu_ready for misses and writes.

---
 rtl/cache_controller.sv | 164 ++++++++++++++++
 tb/tb_cache_controller.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, one-word-per-line cache controller between a
// processor load/store port and a single-cycle main memory.
module cache_controller #(
    parameter int ADDR_BITS  = 5,
    parameter int INDEX_BITS = 3,
    parameter int CNT_BITS   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_BITS-1:0] cpu_address,
    input  logic [31:0]          cpu_wdata,
    input  logic                 cpu_read,
    input  logic                 cpu_write,
    output logic [31:0]          cpu_rdata,
    output logic                 cpu_ready,
    output logic [ADDR_BITS-1:0] mem_address,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata,
    output logic                 mem_write_signal,
    output logic                 mem_read_signal,
    output logic                 match,
    output logic [CNT_BITS-1:0]  hit_count,
    output logic [CNT_BITS-1:0]  miss_count,
    output logic [2:0]           state_dbg
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = ADDR_BITS - INDEX_BITS;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MREAD  = 3'd1,
        MFILL  = 3'd2,
        MWRITE = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t               state, state_d;
    logic [LINES-1:0]     valid;
    logic [TAG_BITS-1:0]  tag_mem  [LINES];
    logic [31:0]          data_mem [LINES];

    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   tag;
    logic                  hit;

    logic                 ready_d, rd_d, wr_d, match_d;
    logic [31:0]          rdata_d, wdata_d;
    logic [ADDR_BITS-1:0] addr_d;
    logic                 hit_inc, miss_inc, fill_en, wr_hit_en;

    assign index     = cpu_address[INDEX_BITS-1:0];
    assign tag       = cpu_address[ADDR_BITS-1:INDEX_BITS];
    assign hit       = valid[index] && (tag_mem[index] == tag);
    assign state_dbg = state;

    // Handshake: cpu_read/cpu_write act as a request held (with stable address
    // and data) until the one-cycle cpu_ready pulse; a request still present
    // once the controller is back in IDLE is taken as a brand-new access.
    // Every output is a flop loaded with the value for the state being entered.
    always_comb begin
        state_d   = state;
        ready_d   = 1'b0;
        rd_d      = 1'b0;
        wr_d      = 1'b0;
        match_d   = 1'b0;
        addr_d    = '0;
        wdata_d   = '0;
        rdata_d   = cpu_rdata;
        hit_inc   = 1'b0;
        miss_inc  = 1'b0;
        fill_en   = 1'b0;
        wr_hit_en = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_write) begin
                    state_d   = MWRITE;
                    wr_d      = 1'b1;
                    addr_d    = cpu_address;
                    wdata_d   = cpu_wdata;
                    match_d   = hit;
                    wr_hit_en = hit;
                end else if (cpu_read) begin
                    if (hit) begin
                        state_d = RESP;
                        ready_d = 1'b1;
                        rdata_d = data_mem[index];
                        match_d = 1'b1;
                        hit_inc = 1'b1;
                    end else begin
                        state_d  = MREAD;
                        rd_d     = 1'b1;
                        addr_d   = cpu_address;
                        miss_inc = 1'b1;
                    end
                end
            end
            MREAD: begin
                // Memory drove mem_rdata on the falling edge of this cycle.
                state_d = MFILL;
                rdata_d = mem_rdata;
                fill_en = 1'b1;
            end
            MFILL: begin
                state_d = RESP;
                ready_d = 1'b1;
            end
            MWRITE: begin
                state_d = RESP;
                ready_d = 1'b1;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            valid            <= '0;
            cpu_ready        <= 1'b0;
            cpu_rdata        <= '0;
            mem_address      <= '0;
            mem_wdata        <= '0;
            mem_read_signal  <= 1'b0;
            mem_write_signal <= 1'b0;
            match            <= 1'b0;
            hit_count        <= '0;
            miss_count       <= '0;
        end else begin
            state            <= state_d;
            cpu_ready        <= ready_d;
            cpu_rdata        <= rdata_d;
            mem_address      <= addr_d;
            mem_wdata        <= wdata_d;
            mem_read_signal  <= rd_d;
            mem_write_signal <= wr_d;
            match            <= match_d;
            if (fill_en) begin
                valid[index] <= 1'b1;
            end
            if (hit_inc && (hit_count != {CNT_BITS{1'b1}})) begin
                hit_count <= hit_count + 1'b1;
            end
            if (miss_inc && (miss_count != {CNT_BITS{1'b1}})) begin
                miss_count <= miss_count + 1'b1;
            end
        end
    end

    // Tags and data are not reset; clearing valid is enough to invalidate.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[index]  <= tag;
            data_mem[index] <= mem_rdata;
        end else if (wr_hit_en) begin
            data_mem[index] <= cpu_wdata;
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: a behavioural main memory, a driver
// task returning what it observed, and per-scenario tasks with a data scoreboard.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  cpu_address = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_read = 1'b0;
  logic        cpu_write = 1'b0;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic [4:0]  mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_write_signal;
  logic        mem_read_signal;
  logic        match;
  logic [7:0]  hit_count;
  logic [7:0]  miss_count;
  logic [2:0]  state_dbg;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  cache_controller #(.ADDR_BITS(5), .INDEX_BITS(3), .CNT_BITS(8)) dut (
    .clk(clk), .reset(reset),
    .cpu_address(cpu_address), .cpu_wdata(cpu_wdata),
    .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_write_signal(mem_write_signal), .mem_read_signal(mem_read_signal),
    .match(match), .hit_count(hit_count), .miss_count(miss_count),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // main memory model: writes on posedge, read data updated on negedge
  logic [31:0] mem [0:31];
  logic        mem_init = 1'b0;
  logic        pre_we = 1'b0;
  logic [4:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  function automatic logic [31:0] init_word(input logic [4:0] a);
    return {16'h5EED, 11'd0, a};
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] = init_word(5'(i));
    end else if (pre_we) begin
      mem[pre_addr] = pre_data;
    end else if (mem_write_signal) begin
      mem[mem_address] = mem_wdata;
    end
  end

  always @(negedge clk) begin
    if (mem_read_signal) mem_rdata = mem[mem_address];
  end

  // bench-side expectations
  logic [31:0] shadow [0:31];
  logic        model_valid [0:7];
  logic [1:0]  model_tag [0:7];

  typedef struct {
    int          lat;
    int          n_rd;
    int          n_wr;
    int          n_both;
    logic [4:0]  s_addr;
    logic [31:0] s_wdata;
    logic        s_match;
    logic [31:0] rdata;
    logic        r_match;
  } obs_t;

  // driver tasks
  task automatic do_reset(input bit init);
    @(negedge clk);
    reset = 1'b1;
    mem_init = init;
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    mem_init = 1'b0;
    for (int i = 0; i < 8; i++) model_valid[i] = 1'b0;
    if (init) for (int i = 0; i < 32; i++) shadow[i] = init_word(5'(i));
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
    shadow[a] = d;
  endtask

  // Latency counts the cycle the request is first presented as cycle 1.
  task automatic drive(input logic rd, input logic wr, input logic [4:0] addr,
                       input logic [31:0] wd, output obs_t o);
    o = '{lat: -1, n_rd: 0, n_wr: 0, n_both: 0, s_addr: '0, s_wdata: '0,
          s_match: 1'b0, rdata: '0, r_match: 1'b0};
    @(negedge clk);
    cpu_address = addr;
    cpu_wdata = wd;
    cpu_read = rd;
    cpu_write = wr;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (mem_read_signal) begin
        o.n_rd++;
        o.s_addr = mem_address;
        o.s_match = match;
      end
      if (mem_write_signal) begin
        o.n_wr++;
        o.s_addr = mem_address;
        o.s_wdata = mem_wdata;
        o.s_match = match;
      end
      if (mem_read_signal && mem_write_signal) o.n_both++;
      if (cpu_ready) begin
        o.lat = c + 1;
        o.rdata = cpu_rdata;
        o.r_match = match;
        break;
      end
    end
    cpu_read = 1'b0;
    cpu_write = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    do_reset(1'b1);
    total++;
    if ({cpu_ready, cpu_rdata, mem_address, mem_wdata, mem_read_signal, mem_write_signal, match} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got rdy=%0b rdata=%h addr=%0d wdata=%h rd=%0b wr=%0b match=%0b, want all 0",
               cpu_ready, cpu_rdata, mem_address, mem_wdata, mem_read_signal, mem_write_signal, match);
    end
    total++;
    if ({hit_count, miss_count} !== 16'd0) begin
      bad++;
      $display("FAIL reset_counters: got hit=%0d miss=%0d want 0 0", hit_count, miss_count);
    end
    total++;
    if (state_dbg !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
  endtask

  task automatic test_miss_then_hit();
    obs_t o;
    logic [31:0] e;
    preload(5'd5, 32'hDEADBEEF);
    exp_q.push_back(32'hDEADBEEF);
    drive(1'b1, 1'b0, 5'd5, '0, o);
    e = exp_q.pop_front();
    total++; if (o.rdata !== e) begin bad++; $display("FAIL miss5_data: got %h want %h", o.rdata, e); end
    total++; if (o.lat !== 4) begin bad++; $display("FAIL miss5_latency: got %0d want 4", o.lat); end
    total++;
    if (o.n_rd !== 1 || o.n_wr !== 0 || o.s_addr !== 5'd5 || o.s_match !== 1'b0) begin
      bad++;
      $display("FAIL miss5_strobe: got rd=%0d wr=%0d addr=%0d match=%0b want 1 0 5 0", o.n_rd, o.n_wr, o.s_addr, o.s_match);
    end
    total++; if (miss_count !== 8'd1) begin bad++; $display("FAIL miss5_count: got %0d want 1", miss_count); end

    exp_q.push_back(32'hDEADBEEF);
    drive(1'b1, 1'b0, 5'd5, '0, o);
    e = exp_q.pop_front();
    total++; if (o.rdata !== e) begin bad++; $display("FAIL hit5_data: got %h want %h", o.rdata, e); end
    total++; if (o.lat !== 2) begin bad++; $display("FAIL hit5_latency: got %0d want 2", o.lat); end
    total++;
    if (o.n_rd !== 0 || o.n_wr !== 0 || o.r_match !== 1'b1) begin
      bad++;
      $display("FAIL hit5_strobe: got rd=%0d wr=%0d match=%0b want 0 0 1", o.n_rd, o.n_wr, o.r_match);
    end
    total++; if (hit_count !== 8'd1) begin bad++; $display("FAIL hit5_count: got %0d want 1", hit_count); end
  endtask

  task automatic test_write_hit();
    obs_t o;
    logic [31:0] e;
    drive(1'b0, 1'b1, 5'd5, 32'h12345678, o);
    total++; if (o.lat !== 3) begin bad++; $display("FAIL wrhit_latency: got %0d want 3", o.lat); end
    total++;
    if (o.n_wr !== 1 || o.n_rd !== 0 || o.s_addr !== 5'd5 || o.s_wdata !== 32'h12345678 || o.s_match !== 1'b1) begin
      bad++;
      $display("FAIL wrhit_strobe: got wr=%0d rd=%0d addr=%0d data=%h match=%0b want 1 0 5 12345678 1",
               o.n_wr, o.n_rd, o.s_addr, o.s_wdata, o.s_match);
    end
    total++; if (mem[5] !== 32'h12345678) begin bad++; $display("FAIL wrhit_mem: got %h want 12345678", mem[5]); end
    exp_q.push_back(32'h12345678);
    drive(1'b1, 1'b0, 5'd5, '0, o);
    e = exp_q.pop_front();
    total++; if (o.rdata !== e) begin bad++; $display("FAIL wrhit_read_data: got %h want %h", o.rdata, e); end
    total++;
    if (o.lat !== 2 || o.n_rd !== 0) begin
      bad++;
      $display("FAIL wrhit_read_hit: got lat=%0d rd=%0d want 2 0", o.lat, o.n_rd);
    end
  endtask

  task automatic test_write_miss();
    obs_t o;
    logic [31:0] e;
    drive(1'b0, 1'b1, 5'd9, 32'hA5A5A5A5, o);
    total++;
    if (o.lat !== 3 || o.n_wr !== 1 || o.s_match !== 1'b0 || o.s_addr !== 5'd9) begin
      bad++;
      $display("FAIL wrmiss_strobe: got lat=%0d wr=%0d match=%0b addr=%0d want 3 1 0 9", o.lat, o.n_wr, o.s_match, o.s_addr);
    end
    total++; if (mem[9] !== 32'hA5A5A5A5) begin bad++; $display("FAIL wrmiss_mem: got %h want a5a5a5a5", mem[9]); end
    exp_q.push_back(32'hA5A5A5A5);
    drive(1'b1, 1'b0, 5'd9, '0, o);
    e = exp_q.pop_front();
    total++; if (o.rdata !== e) begin bad++; $display("FAIL wrmiss_read_data: got %h want %h", o.rdata, e); end
    total++;
    if (o.lat !== 4 || o.n_rd !== 1) begin
      bad++;
      $display("FAIL wrmiss_no_alloc: got lat=%0d rd=%0d want 4 1", o.lat, o.n_rd);
    end
  endtask

  task automatic test_conflict();
    obs_t o;
    logic [31:0] e;
    logic [4:0] seq [3];
    logic [31:0] val [3];
    seq = '{5'd3, 5'd11, 5'd3};
    val = '{32'h0000_3333, 32'h1111_BBBB, 32'h0000_3333};
    do_reset(1'b0);
    preload(5'd3, 32'h0000_3333);
    preload(5'd11, 32'h1111_BBBB);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(val[i]);
      drive(1'b1, 1'b0, seq[i], '0, o);
      e = exp_q.pop_front();
      total++;
      if (o.rdata !== e || o.lat !== 4) begin
        bad++;
        $display("FAIL conflict_%0d: got data=%h lat=%0d want %h 4", i, o.rdata, o.lat, e);
      end
    end
    total++; if (miss_count !== 8'd3) begin bad++; $display("FAIL conflict_count: got %0d want 3", miss_count); end
  endtask

  task automatic test_simultaneous();
    obs_t o;
    logic [31:0] e;
    drive(1'b1, 1'b1, 5'd2, 32'h0BADF00D, o);
    total++;
    if (o.lat !== 3 || o.n_wr !== 1 || o.n_rd !== 0 || o.s_wdata !== 32'h0BADF00D) begin
      bad++;
      $display("FAIL simul_write_path: got lat=%0d wr=%0d rd=%0d data=%h want 3 1 0 0badf00d", o.lat, o.n_wr, o.n_rd, o.s_wdata);
    end
    total++; if (miss_count !== 8'd3) begin bad++; $display("FAIL simul_no_read: got miss=%0d want 3", miss_count); end
    exp_q.push_back(32'h0BADF00D);
    drive(1'b1, 1'b0, 5'd2, '0, o);
    e = exp_q.pop_front();
    total++;
    if (o.rdata !== e || o.lat !== 4) begin
      bad++;
      $display("FAIL simul_readback: got data=%h lat=%0d want %h 4", o.rdata, o.lat, e);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    logic [31:0] e;
    do_reset(1'b1);
    drive(1'b1, 1'b0, 5'd6, '0, o);
    drive(1'b1, 1'b0, 5'd6, '0, o);
    total++; if (o.lat !== 2) begin bad++; $display("FAIL rstmid_prehit: got lat=%0d want 2", o.lat); end
    @(negedge clk);
    cpu_address = 5'd14;
    cpu_read = 1'b1;
    @(negedge clk);
    total++; if (mem_read_signal !== 1'b1) begin bad++; $display("FAIL rstmid_in_mread: got rd=%0b want 1", mem_read_signal); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cpu_read = 1'b0;
    total++;
    if ({cpu_ready, cpu_rdata, mem_address, mem_wdata, mem_read_signal, mem_write_signal, match, hit_count, miss_count} !== '0) begin
      bad++;
      $display("FAIL rstmid_outputs: got rdy=%0b rdata=%h addr=%0d rd=%0b match=%0b hit=%0d miss=%0d want all 0",
               cpu_ready, cpu_rdata, mem_address, mem_read_signal, match, hit_count, miss_count);
    end
    total++; if (state_dbg !== 3'd0) begin bad++; $display("FAIL rstmid_state: got %0d want 0", state_dbg); end
    exp_q.push_back(init_word(5'd6));
    drive(1'b1, 1'b0, 5'd6, '0, o);
    e = exp_q.pop_front();
    total++;
    if (o.rdata !== e || o.lat !== 4) begin
      bad++;
      $display("FAIL rstmid_now_miss: got data=%h lat=%0d want %h 4", o.rdata, o.lat, e);
    end
  endtask

  task automatic test_saturation();
    obs_t o;
    logic [31:0] e;
    int want;
    do_reset(1'b1);
    drive(1'b1, 1'b0, 5'd7, '0, o);
    for (int i = 0; i < 300; i++) begin
      exp_q.push_back(init_word(5'd7));
      drive(1'b1, 1'b0, 5'd7, '0, o);
      e = exp_q.pop_front();
      want = (i + 1 > 255) ? 255 : i + 1;
      total++;
      if (o.rdata !== e || o.lat !== 2 || int'(hit_count) !== want) begin
        bad++;
        $display("FAIL sat_hit_%0d: got data=%h lat=%0d hit=%0d want %h 2 %0d", i, o.rdata, o.lat, hit_count, e, want);
      end
    end
    total++; if (miss_count !== 8'd1) begin bad++; $display("FAIL sat_miss_count: got %0d want 1", miss_count); end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    logic [31:0] e;
    logic [4:0] a;
    logic [31:0] wd;
    logic is_wr, mhit;
    int exp_hits, exp_miss, want_lat;
    do_reset(1'b1);
    exp_hits = 0;
    exp_miss = 0;
    for (int i = 0; i < 60; i++) begin
      a = 5'($urandom_range(0, 15));
      is_wr = ($urandom_range(0, 2) == 0);
      wd = $urandom;
      mhit = model_valid[a[2:0]] && (model_tag[a[2:0]] == a[4:3]);
      if (is_wr) begin
        drive(1'b0, 1'b1, a, wd, o);
        shadow[a] = wd;
        total++;
        if (o.lat !== 3 || o.n_wr !== 1 || o.n_rd !== 0 || o.s_addr !== a || o.s_wdata !== wd || o.s_match !== mhit) begin
          bad++;
          $display("FAIL b2b_write_%0d: got lat=%0d wr=%0d addr=%0d data=%h match=%0b want 3 1 %0d %h %0b",
                   i, o.lat, o.n_wr, o.s_addr, o.s_wdata, o.s_match, a, wd, mhit);
        end
      end else begin
        exp_q.push_back(shadow[a]);
        want_lat = mhit ? 2 : 4;
        if (mhit) exp_hits++; else exp_miss++;
        drive(1'b1, 1'b0, a, '0, o);
        e = exp_q.pop_front();
        model_valid[a[2:0]] = 1'b1;
        model_tag[a[2:0]] = a[4:3];
        total++;
        if (o.rdata !== e || o.lat !== want_lat || o.n_rd !== (mhit ? 0 : 1)) begin
          bad++;
          $display("FAIL b2b_read_%0d: addr=%0d got data=%h lat=%0d rd=%0d want %h %0d %0d",
                   i, a, o.rdata, o.lat, o.n_rd, e, want_lat, mhit ? 0 : 1);
        end
      end
      total++; if (o.n_both !== 0) begin bad++; $display("FAIL b2b_strobe_overlap_%0d: got %0d want 0", i, o.n_both); end
    end
    total++;
    if (int'(hit_count) !== exp_hits || int'(miss_count) !== exp_miss) begin
      bad++;
      $display("FAIL b2b_counters: got hit=%0d miss=%0d want %0d %0d", hit_count, miss_count, exp_hits, exp_miss);
    end
  endtask

  // sequence and final report
  initial begin
    for (int i = 0; i < 32; i++) shadow[i] = init_word(5'(i));
    for (int i = 0; i < 8; i++) begin
      model_valid[i] = 1'b0;
      model_tag[i] = '0;
    end
    test_reset();
    test_miss_then_hit();
    test_write_hit();
    test_write_miss();
    test_conflict();
    test_simultaneous();
    test_reset_mid();
    test_saturation();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
